// File: rtl/bus_slave_responder.sv
// bus_slave_responder
//
// Responder-side controller for the shared 32-bit memory bus. It answers the
// fixed 16-byte (four 32-bit beats) transfers issued by bus masters and turns
// each one into a single 128-bit access on the memory side.
//
// Ports:
//   BUS_CLK         bus clock, everything changes on its rising edge
//   RST             synchronous active-low reset
//   D               bidirectional bus data, driven only while returning read beats
//   A, SIZE, RW     address-phase request (address, byte count, 1 = write)
//   DEST_IN         select line, 1 = the current address phase targets this unit
//   ACK_OUT         one-cycle acknowledge to the master
//   MEM_EN, MEM_WR  memory request and its type (1 = write), held until MEM_R
//   MEM_A           latched line address (low nibble cleared)
//   MEM_WRITE_DATA  captured write line, beat k in bits [32k+31:32k]
//   MEM_READ_DATA   memory read line, valid with MEM_R
//   MEM_R           one-cycle memory completion pulse
//   BUSY            high in every state except IDLE
module bus_slave_responder (
    input  logic         BUS_CLK,
    input  logic         RST,
    inout  wire  [31:0]  D,
    input  logic [15:0]  A,
    input  logic [11:0]  SIZE,
    input  logic         RW,
    input  logic         DEST_IN,
    output logic         ACK_OUT,
    output logic         MEM_EN,
    output logic         MEM_WR,
    output logic [15:0]  MEM_A,
    output logic [127:0] MEM_WRITE_DATA,
    input  logic [127:0] MEM_READ_DATA,
    input  logic         MEM_R,
    output logic         BUSY
);

    typedef enum logic [6:0] {
        IDLE   = 7'b0000001,
        ACK_WR = 7'b0000010,
        CAP    = 7'b0000100,
        MEMWR  = 7'b0001000,
        MEMRD  = 7'b0010000,
        ACK_RD = 7'b0100000,
        DRV    = 7'b1000000
    } state_t;

    localparam logic [11:0] LINE_SIZE = 12'h010;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [15:0]      addr_q, addr_d;
    logic [3:0][31:0] line_q, line_d;

    logic             drive_en;
    logic [31:0]      drive_word;

    // State register and datapath flops. Reset clears everything, which also
    // releases D on the same edge because the drive enable is state-decoded.
    always_ff @(posedge BUS_CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 16'h0000;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    // Next-state and datapath update. The transfer direction is not stored
    // separately: it is carried by which branch of the FSM we are in.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        line_d  = line_q;

        case (state_q)
            IDLE: begin
                // Unsupported sizes are silently ignored
                if (DEST_IN && (SIZE == LINE_SIZE)) begin
                    addr_d  = A;
                    state_d = RW ? ACK_WR : MEMRD;
                end
            end
            ACK_WR: begin
                cnt_d   = 2'd0;
                state_d = CAP;
            end
            CAP: begin
                line_d[cnt_q] = D;
                cnt_d         = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = MEMWR;
                end
            end
            MEMWR: begin
                if (MEM_R) begin
                    state_d = IDLE;
                end
            end
            MEMRD: begin
                if (MEM_R) begin
                    line_d  = MEM_READ_DATA;
                    state_d = ACK_RD;
                end
            end
            ACK_RD: begin
                cnt_d   = 2'd0;
                state_d = DRV;
            end
            DRV: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs, decoded from registered state only
    always_comb begin
        ACK_OUT        = (state_q == ACK_WR) || (state_q == ACK_RD);
        MEM_EN         = (state_q == MEMWR) || (state_q == MEMRD);
        MEM_WR         = (state_q == MEMWR);
        BUSY           = (state_q != IDLE);
        MEM_A          = addr_q & 16'hFFF0;
        MEM_WRITE_DATA = line_q;
        drive_en       = (state_q == DRV);
        drive_word     = line_q[cnt_q];
    end

    assign D = drive_en ? drive_word : 32'bz;

endmodule

// File: tb/tb_bus_slave_responder.sv
// tb_bus_slave_responder
//
// Directed self-checking bench for bus_slave_responder. A small behavioral
// memory answers MEM_EN after a programmable number of wait cycles. The data
// bus is a pulled-up net, so a released D reads back as all ones.
module tb_bus_slave_responder;

    logic         busClk = 1'b0;
    logic         rst;
    tri1  [31:0]  dBus;
    logic [15:0]  addr;
    logic [11:0]  size;
    logic         rw;
    logic         destIn;
    wire          ackOut;
    wire          memEn;
    wire          memWr;
    wire  [15:0]  memA;
    wire  [127:0] memWriteData;
    logic [127:0] memReadData = '0;
    logic         memR = 1'b0;
    wire          busy;

    logic         tbDriveEn;
    logic [31:0]  tbData;

    logic [127:0] memArray [0:15];
    int           memWait;
    int           waitCnt = 0;

    int           checkCount = 0;
    int           passCount = 0;
    int           idleCycles;

    localparam logic [31:0]  RELEASED   = 32'hFFFF_FFFF;
    localparam logic [127:0] WR_LINE    = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] RD_LINE    = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    localparam logic [127:0] B2B_LINE   = 128'h0BAD_F00D_1357_9BDF_2468_ACE0_CAFE_BEEF;
    localparam logic [127:0] HOLD_LINE  = 128'h55555555_66666666_77777777_88888888;

    assign dBus = tbDriveEn ? tbData : 32'bz;

    bus_slave_responder dut (
        .BUS_CLK        (busClk),
        .RST            (rst),
        .D              (dBus),
        .A              (addr),
        .SIZE           (size),
        .RW             (rw),
        .DEST_IN        (destIn),
        .ACK_OUT        (ackOut),
        .MEM_EN         (memEn),
        .MEM_WR         (memWr),
        .MEM_A          (memA),
        .MEM_WRITE_DATA (memWriteData),
        .MEM_READ_DATA  (memReadData),
        .MEM_R          (memR),
        .BUSY           (busy)
    );

    always #5 busClk = ~busClk;

    // Behavioral memory: answers on the falling edge after memWait idle
    // cycles of MEM_EN, so the DUT sees MEM_R at the following rising edge.
    always @(negedge busClk) begin
        memR = 1'b0;
        if (memEn) begin
            if (waitCnt >= memWait) begin
                memR    = 1'b1;
                waitCnt = 0;
                if (memWr) begin
                    memArray[memA[7:4]] = memWriteData;
                end else begin
                    memReadData = memArray[memA[7:4]];
                end
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
        end
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepCycle();
        @(posedge busClk);
        #1;
    endtask

    task automatic applyStimulus(input logic dest, input logic rwIn,
                                 input logic [15:0] a, input logic [11:0] sz);
        destIn = dest;
        rw     = rwIn;
        addr   = a;
        size   = sz;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Steps until BUSY drops, bounded; reports how many cycles it took
    task automatic waitIdle(input string tag, output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            stepCycle();
            cycles++;
        end
        checkOutput(tag, busy, 1'b0);
    endtask

    // Presents a write in the current IDLE cycle and runs it up to the first
    // MEMWR cycle, where the memory-side request is checked.
    task automatic writeTransfer(input logic [15:0] a, input logic [127:0] line,
                                 input logic [15:0] expA);
        applyStimulus(1'b1, 1'b1, a, 12'h010);
        stepCycle();
        checkOutput("wr ack", ackOut, 1'b1);
        checkOutput("wr busy", busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 12'h000);
        stepCycle();
        for (int k = 0; k < 4; k++) begin
            tbDriveEn = 1'b1;
            tbData    = line[32*k +: 32];
            checkOutput("wr cap no ack", ackOut, 1'b0);
            stepCycle();
        end
        tbDriveEn = 1'b0;
        checkOutput("wr mem_en", memEn, 1'b1);
        checkOutput("wr mem_wr", memWr, 1'b1);
        checkOutput("wr mem_a", memA, expA);
        checkOutput("wr data", memWriteData, line);
    endtask

    // Presents a read in the current IDLE cycle and follows it through the
    // returned beats. resetBeat >= 0 pulls reset during that DRV beat.
    task automatic readTransfer(input logic [15:0] a, input logic [127:0] line,
                                input logic [15:0] expA, input int waits,
                                input int resetBeat);
        memWait = waits;
        applyStimulus(1'b1, 1'b0, a, 12'h010);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 16'h0000, 12'h000);
        checkOutput("rd mem_a", memA, expA);
        for (int i = 0; i <= waits; i++) begin
            checkOutput("rd mem_en", memEn, 1'b1);
            checkOutput("rd mem_wr", memWr, 1'b0);
            checkOutput("rd early ack", ackOut, 1'b0);
            stepCycle();
        end
        checkOutput("rd ack", ackOut, 1'b1);
        checkOutput("rd ack released", dBus, RELEASED);
        stepCycle();
        for (int k = 0; k < 4; k++) begin
            checkOutput("rd beat", dBus, line[32*k +: 32]);
            checkOutput("rd beat no ack", ackOut, 1'b0);
            if (k == resetBeat) begin
                rst = 1'b0;
                stepCycle();
                checkOutput("rst drv released", dBus, RELEASED);
                checkOutput("rst drv ack", ackOut, 1'b0);
                checkOutput("rst drv busy", busy, 1'b0);
                rst = 1'b1;
                return;
            end
            stepCycle();
        end
        checkOutput("rd released", dBus, RELEASED);
        checkOutput("rd done", busy, 1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        tbDriveEn = 1'b0;
        tbData    = 32'h0;
        memWait   = 0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 12'h000);
        for (int i = 0; i < 16; i++) begin
            memArray[i] = '0;
        end
        memArray[9] = RD_LINE;

        // Reset state
        stepCycle();
        stepCycle();
        checkOutput("rst busy", busy, 1'b0);
        checkOutput("rst ack", ackOut, 1'b0);
        checkOutput("rst mem_en", memEn, 1'b0);
        checkOutput("rst mem_wr", memWr, 1'b0);
        checkOutput("rst mem_a", memA, 16'h0000);
        checkOutput("rst wdata", memWriteData, 128'h0);
        checkOutput("rst d", dBus, RELEASED);
        rst = 1'b1;
        stepCycle();

        // Write with zero memory wait: back in IDLE one cycle after MEMWR
        memWait = 0;
        writeTransfer(16'h1234, WR_LINE, 16'h1230);
        waitIdle("wr idle", idleCycles);
        checkOutput("wr occupancy", idleCycles, 1);
        checkOutput("wr mem stored", memArray[3], WR_LINE);

        // Read with three wait cycles
        stepCycle();
        readTransfer(16'h4A98, RD_LINE, 16'h4A90, 3, -1);

        // Unsupported size is ignored
        stepCycle();
        applyStimulus(1'b1, 1'b1, 16'h1000, 12'h004);
        stepCycle();
        checkOutput("size ack", ackOut, 1'b0);
        checkOutput("size busy", busy, 1'b0);
        checkOutput("size mem_en", memEn, 1'b0);
        stepCycle();
        checkOutput("size busy later", busy, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 12'h000);

        // Reset on the second DRV beat, then a normal read
        readTransfer(16'h4A94, RD_LINE, 16'h4A90, 0, 1);
        readTransfer(16'h4A98, RD_LINE, 16'h4A90, 1, -1);

        // Back-to-back: write, then read on the first IDLE cycle
        memWait = 0;
        writeTransfer(16'h5670, B2B_LINE, 16'h5670);
        stepCycle();
        checkOutput("b2b idle", busy, 1'b0);
        readTransfer(16'h5674, B2B_LINE, 16'h5670, 0, -1);

        // Select and address changes during MEMWR are ignored
        memWait = 4;
        writeTransfer(16'h2468, HOLD_LINE, 16'h2460);
        applyStimulus(1'b1, 1'b0, 16'hFFFF, 12'h010);
        stepCycle();
        checkOutput("hold mem_en", memEn, 1'b1);
        checkOutput("hold mem_wr", memWr, 1'b1);
        checkOutput("hold mem_a", memA, 16'h2460);
        checkOutput("hold ack", ackOut, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 12'h000);
        waitIdle("hold idle", idleCycles);
        checkOutput("hold wait cycles", idleCycles, 4);
        stepCycle();
        checkOutput("hold no queued req", busy, 1'b0);
        checkOutput("hold mem stored", memArray[6], HOLD_LINE);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
